rcu_pll_seq: RTL and testbench
==============================

# rcu_pll_seq

PLL power-up and lock sequencer for the reset/clock unit. It runs on the buffered low-frequency reference oscillator and drives the PLL macro's power-down, reset and configuration inputs. It filters the PLL's raw lock indication into the clean, glitch-free `pll_lock_o` that the RCU uses to gate the PLL-derived clock muxes and to release the post-divider reset synchronizers. It also detects loss of lock and lock timeouts, re-sequences the PLL on configuration changes, and exposes status for software.

## Interface
- `CFG_WIDTH`, 3, width of the PLL configuration word (`clk_cfg`).
- `SETTLE_WIDTH`, 8, width of the reset-settle counter.
- `LOCK_WIDTH`, 8, width of the lock-filter counter.
- `TMO_WIDTH`, 16, width of the lock-timeout counter.

Ports:
- `clk_i` in 1: reference clock (buffered LF oscillator).
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `pll_en_i` in 1: PLL enable strap; level.
- `clk_cfg_i` in CFG_WIDTH: requested PLL configuration; quasi-static.
- `settle_cyc_i` in SETTLE_WIDTH: cycles the PLL is held in reset after power-up or reconfiguration.
- `lock_cyc_i` in LOCK_WIDTH: consecutive synchronized-lock cycles required (0 is treated as 1).
- `timeout_i` in TMO_WIDTH: maximum cycles in WAIT; 0 disables the timeout.
- `pll_lock_raw_i` in 1: raw PLL lock; asynchronous, passed through an internal 2-flop synchronizer.
- `pll_pd_o` out 1: PLL power-down.
- `pll_rst_o` out 1: PLL reset.
- `pll_cfg_o` out CFG_WIDTH: registered configuration applied to the PLL.
- `pll_lock_o` out 1: filtered stable lock.
- `lock_lost_o` out 1: one-cycle pulse on loss of lock.
- `timeout_o` out 1: lock timeout flag.
- `relock_cnt_o` out 8: saturating count of lock losses.
- `state_o` out 3: current state, encoded OFF=0, RST=1, WAIT=2, LOCKED=3, FAIL=4.

## Operation
**States and outputs**
- **OFF:** `pll_pd_o`=1, `pll_rst_o`=1.
- **RST:** `pll_pd_o`=0, `pll_rst_o`=1.
- **WAIT and LOCKED:** both 0.
- **FAIL:** both 1.
- `pll_lock_o` = (state==LOCKED).
- `timeout_o` = (state==FAIL).
- All outputs are registered or direct state decodes.

**Transitions.** Priority per cycle: disable > config change > lock loss/timeout > normal progress.
- **Any state, `pll_en_i`=0:** go to OFF.
- **OFF, `pll_en_i`=1:**
  - Capture `clk_cfg_i` into `pll_cfg_o`.
  - Load the settle counter with `settle_cyc_i`.
  - Go to RST.
- **RST:**
  - Settle counter decrements each cycle.
  - At 0, go to WAIT and clear the filter and timeout counters.
  - `settle_cyc_i`=0 gives exactly 1 cycle in RST.
- **RST/WAIT/LOCKED/FAIL with `clk_cfg_i` != `pll_cfg_o`:**
  - Recapture the configuration.
  - Reload the settle counter.
  - Go to RST. From RST this restarts the settle period.
- **WAIT:**
  - Filter counter increments while synced lock=1 and clears to 0 on synced lock=0.
  - When the filter count reaches max(`lock_cyc_i`,1), go to LOCKED.
  - Timeout counter increments every cycle. If `timeout_i`!=0 and `timeout_i` cycles have elapsed without reaching LOCKED, go to FAIL.
  - If both the lock condition and the timeout occur in the same cycle, lock wins.
- **LOCKED, synced lock=0:**
  - `lock_lost_o` pulses for 1 cycle.
  - `relock_cnt_o` increments, saturating at 255.
  - Go to RST, keeping the same configuration.
- **FAIL:** hold until `pll_en_i`=0 or a configuration change.

**Other rules**
- `relock_cnt_o` clears only on `rst_n_i`.
- Parameter inputs (`settle_cyc_i`, `lock_cyc_i`, `timeout_i`) are sampled at counter load or compare. Changing them mid-phase affects only the current compare.

## Timing
**Reset values**
- `pll_pd_o`=1, `pll_rst_o`=1.
- `pll_cfg_o`=0, `pll_lock_o`=0, `lock_lost_o`=0, `timeout_o`=0.
- `relock_cnt_o`=0, `state_o`=0.
- Synchronizer flops = 0.

**Cycle-level behaviour**
- **Reset mid-operation:** `rst_n_i` low asynchronously forces all reset values, including dropping `pll_lock_o` immediately.
- **Enable to RST:** `pll_en_i` rising → `state_o`=RST one edge later.
- **Time in RST:** `settle_cyc_i`=S gives S+1 cycles with `pll_pd_o`=0, `pll_rst_o`=1.
- **Synchronizer latency:** 2 edges.
- **Lock assertion:** `pll_lock_o` rises N edges after the synced lock first reads 1, where N=max(`lock_cyc_i`,1).
- **Glitch rejection:** a raw-lock glitch shorter than N cycles never asserts `pll_lock_o`.
- **Lock loss:** `pll_lock_o` falls, and `lock_lost_o` pulses in the same cycle, 1 edge after synced lock reads 0. That is 3 edges after raw lock is sampled low.
- **Disable:** `pll_en_i`=0 drops `pll_lock_o` and raises `pll_pd_o` on the next edge.
- **Config change:** a `clk_cfg_i` change drops `pll_lock_o` on the next edge, and `pll_cfg_o` updates on that same edge.

## Test plan
- **Normal lock:** reset → `pll_en_i`=1, `settle_cyc_i`=4, `lock_cyc_i`=8, raw lock high 10 cycles after WAIT entry → 5 cycles in RST; `pll_lock_o` rises 10 edges after raw lock goes high; `relock_cnt_o`=0.
- **Glitch rejection:** in WAIT with `lock_cyc_i`=8, raw lock high 5 cycles, low 1 cycle, then high → filter restarts; lock asserts only after 8 uninterrupted synced cycles.
- **Timeout:** `timeout_i`=20, raw lock held 0 → FAIL after 20 WAIT cycles; `timeout_o`=1, `pll_pd_o`=1. A `clk_cfg_i` change then re-enters RST and clears `timeout_o`.
- **Lock loss:** LOCKED, raw lock low for 1 cycle → `lock_lost_o` 1-cycle pulse, `relock_cnt_o`=1, state RST. Repeated 300 times, `relock_cnt_o` saturates at 255.
- **Reconfigure:** in LOCKED, `clk_cfg_i` 3→5 → next edge `pll_cfg_o`=5, `pll_lock_o`=0, RST, then relock. In the same cycle as the change, `pll_en_i`=0 → OFF wins and `pll_cfg_o` stays 3.
- **Async reset:** async `rst_n_i` pulse during LOCKED → `pll_lock_o`=0 and `pll_pd_o`=1 without waiting for a clock edge; all status cleared.

Source files
------------

// File: rtl/rcu_pll_seq_if.sv
// Signal bundle between the RCU control/status side and the PLL sequencer.
// The master side drives strap, configuration and raw lock; the slave side is the sequencer.
interface rcu_pll_seq_if #(
  parameter int CFG_WIDTH    = 3,
  parameter int SETTLE_WIDTH = 8,
  parameter int LOCK_WIDTH   = 8,
  parameter int TMO_WIDTH    = 16
);
  logic                    pll_en_i;
  logic [CFG_WIDTH-1:0]    clk_cfg_i;
  logic [SETTLE_WIDTH-1:0] settle_cyc_i;
  logic [LOCK_WIDTH-1:0]   lock_cyc_i;
  logic [TMO_WIDTH-1:0]    timeout_i;
  logic                    pll_lock_raw_i;
  logic                    pll_pd_o;
  logic                    pll_rst_o;
  logic [CFG_WIDTH-1:0]    pll_cfg_o;
  logic                    pll_lock_o;
  logic                    lock_lost_o;
  logic                    timeout_o;
  logic [7:0]              relock_cnt_o;
  logic [2:0]              state_o;

  modport master (
    output pll_en_i, clk_cfg_i, settle_cyc_i, lock_cyc_i, timeout_i, pll_lock_raw_i,
    input  pll_pd_o, pll_rst_o, pll_cfg_o, pll_lock_o, lock_lost_o, timeout_o,
           relock_cnt_o, state_o
  );

  modport slave (
    input  pll_en_i, clk_cfg_i, settle_cyc_i, lock_cyc_i, timeout_i, pll_lock_raw_i,
    output pll_pd_o, pll_rst_o, pll_cfg_o, pll_lock_o, lock_lost_o, timeout_o,
           relock_cnt_o, state_o
  );
endinterface

// File: rtl/rcu_pll_seq.sv
// PLL power-up/lock sequencer: drives PLL power-down, reset and config, and filters
// the raw lock into a clean pll_lock_o with loss-of-lock and timeout detection.
module rcu_pll_seq #(
  parameter int CFG_WIDTH    = 3,
  parameter int SETTLE_WIDTH = 8,
  parameter int LOCK_WIDTH   = 8,
  parameter int TMO_WIDTH    = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  rcu_pll_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RST    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t                  state_reg, state_next;
  logic                    sync1_reg, sync2_reg;
  logic [CFG_WIDTH-1:0]    cfg_reg, cfg_next;
  logic [SETTLE_WIDTH-1:0] settle_reg, settle_next;
  logic [LOCK_WIDTH-1:0]   filt_reg, filt_next;
  logic [TMO_WIDTH-1:0]    tmo_reg, tmo_next;
  logic                    lost_reg, lost_next;
  logic [7:0]              relock_reg, relock_next;

  logic                    cfg_change;
  logic [LOCK_WIDTH:0]     lock_target;
  logic [LOCK_WIDTH:0]     filt_inc;
  logic [TMO_WIDTH:0]      tmo_inc;
  logic                    lock_hit;
  logic                    tmo_hit;

  // Compares run one bit wider so a counter at all-ones cannot wrap past the target.
  assign cfg_change  = (bus.clk_cfg_i != cfg_reg);
  assign lock_target = (bus.lock_cyc_i == '0) ? (LOCK_WIDTH+1)'(1) : {1'b0, bus.lock_cyc_i};
  assign filt_inc    = {1'b0, filt_reg} + (LOCK_WIDTH+1)'(1);
  assign tmo_inc     = {1'b0, tmo_reg} + (TMO_WIDTH+1)'(1);
  assign lock_hit    = sync2_reg && (filt_inc >= lock_target);
  assign tmo_hit     = (bus.timeout_i != '0) && (tmo_inc >= {1'b0, bus.timeout_i});

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      state_reg  <= ST_OFF;
      cfg_reg    <= '0;
      settle_reg <= '0;
      filt_reg   <= '0;
      tmo_reg    <= '0;
      lost_reg   <= 1'b0;
      relock_reg <= '0;
    end else begin
      sync1_reg  <= bus.pll_lock_raw_i;
      sync2_reg  <= sync1_reg;
      state_reg  <= state_next;
      cfg_reg    <= cfg_next;
      settle_reg <= settle_next;
      filt_reg   <= filt_next;
      tmo_reg    <= tmo_next;
      lost_reg   <= lost_next;
      relock_reg <= relock_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cfg_next    = cfg_reg;
    settle_next = settle_reg;
    filt_next   = filt_reg;
    tmo_next    = tmo_reg;
    lost_next   = 1'b0;
    relock_next = relock_reg;

    if (!bus.pll_en_i) begin
      state_next = ST_OFF;
    end else if (state_reg == ST_OFF || cfg_change) begin
      cfg_next    = bus.clk_cfg_i;
      settle_next = bus.settle_cyc_i;
      state_next  = ST_RST;
    end else begin
      case (state_reg)
        ST_RST: begin
          if (settle_reg == '0) begin
            state_next = ST_WAIT;
            filt_next  = '0;
            tmo_next   = '0;
          end else begin
            settle_next = settle_reg - SETTLE_WIDTH'(1);
          end
        end
        ST_WAIT: begin
          filt_next = sync2_reg ? filt_inc[LOCK_WIDTH-1:0] : '0;
          tmo_next  = (tmo_reg == '1) ? tmo_reg : tmo_inc[TMO_WIDTH-1:0];
          // A lock reached on the very cycle the timeout expires still counts as locked.
          if (lock_hit) begin
            state_next = ST_LOCKED;
          end else if (tmo_hit) begin
            state_next = ST_FAIL;
          end
        end
        ST_LOCKED: begin
          if (!sync2_reg) begin
            lost_next   = 1'b1;
            relock_next = (relock_reg == 8'hFF) ? relock_reg : relock_reg + 8'd1;
            settle_next = bus.settle_cyc_i;
            state_next  = ST_RST;
          end
        end
        ST_FAIL: state_next = ST_FAIL;
        default: state_next = ST_OFF;
      endcase
    end
  end

  assign bus.pll_pd_o     = (state_reg == ST_OFF) || (state_reg == ST_FAIL);
  assign bus.pll_rst_o    = (state_reg != ST_WAIT) && (state_reg != ST_LOCKED);
  assign bus.pll_cfg_o    = cfg_reg;
  assign bus.pll_lock_o   = (state_reg == ST_LOCKED);
  assign bus.lock_lost_o  = lost_reg;
  assign bus.timeout_o    = (state_reg == ST_FAIL);
  assign bus.relock_cnt_o = relock_reg;
  assign bus.state_o      = state_reg;

endmodule

// File: tb/tb_rcu_pll_seq.sv
// Self-checking bench for rcu_pll_seq: randomized scenarios checked against expectations
// derived from the sequencing rules (edge counts, settle/filter/timeout arithmetic).
module tb_rcu_pll_seq;

  localparam int S_OFF = 0, S_RST = 1, S_WAIT = 2, S_LOCKED = 3, S_FAIL = 4;
  localparam int K_STATE = 0, K_LOCK = 1, K_LOST = 2, K_NOT_STATE = 3;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   relock_model;

  rcu_pll_seq_if #(.CFG_WIDTH(3), .SETTLE_WIDTH(8), .LOCK_WIDTH(8), .TMO_WIDTH(16)) bus ();

  rcu_pll_seq #(.CFG_WIDTH(3), .SETTLE_WIDTH(8), .LOCK_WIDTH(8), .TMO_WIDTH(16)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances edges until the condition holds; n = edges taken, or -1 if the budget ran out.
  task automatic wait_until(input int kind, input int val, input int budget, output int n);
    bit done;
    n = 0;
    done = 0;
    while (!done) begin
      tick();
      n++;
      case (kind)
        K_STATE:     done = (int'(bus.state_o) == val);
        K_LOCK:      done = (int'(bus.pll_lock_o) == val);
        K_LOST:      done = (int'(bus.lock_lost_o) == val);
        default:     done = (int'(bus.state_o) != val);
      endcase
      if (!done && n >= budget) begin
        n = -1;
        done = 1;
      end
    end
  endtask

  // Disable, program the parameters, re-enable and run up to WAIT entry.
  task automatic to_wait(input int s, input int nl, input int t, input int cfg, input bit raw);
    int n;
    bus.pll_en_i = 1'b0;
    tick();
    bus.settle_cyc_i   = 8'(s);
    bus.lock_cyc_i     = 8'(nl);
    bus.timeout_i      = 16'(t);
    bus.clk_cfg_i      = 3'(cfg);
    bus.pll_lock_raw_i = raw;
    bus.pll_en_i       = 1'b1;
    wait_until(K_STATE, S_WAIT, 600, n);
    n_cmp++;
    if (n < 0) begin
      n_bad++;
      $display("FAIL reach_wait: got timeout want state %0d", S_WAIT);
    end
  endtask

  task automatic test_reset();
    n_cmp += 8;
    if (bus.pll_pd_o !== 1'b1)       begin n_bad++; $display("FAIL rst_pd: got %0b want 1", bus.pll_pd_o); end
    if (bus.pll_rst_o !== 1'b1)      begin n_bad++; $display("FAIL rst_rst: got %0b want 1", bus.pll_rst_o); end
    if (bus.pll_cfg_o !== 3'd0)      begin n_bad++; $display("FAIL rst_cfg: got %0d want 0", bus.pll_cfg_o); end
    if (bus.pll_lock_o !== 1'b0)     begin n_bad++; $display("FAIL rst_lock: got %0b want 0", bus.pll_lock_o); end
    if (bus.lock_lost_o !== 1'b0)    begin n_bad++; $display("FAIL rst_lost: got %0b want 0", bus.lock_lost_o); end
    if (bus.timeout_o !== 1'b0)      begin n_bad++; $display("FAIL rst_tmo: got %0b want 0", bus.timeout_o); end
    if (bus.relock_cnt_o !== 8'd0)   begin n_bad++; $display("FAIL rst_relock: got %0d want 0", bus.relock_cnt_o); end
    if (bus.state_o !== 3'd0)        begin n_bad++; $display("FAIL rst_state: got %0d want 0", bus.state_o); end
    $display("[%0t] reset: state=%0d pd=%0b rst=%0b", $time, bus.state_o, bus.pll_pd_o, bus.pll_rst_o);
  endtask

  // One full power-up: RST length = s+1, lock edges after raw rise = 2 + max(nl,1).
  task automatic run_lock(input string tag, input int s, input int nl, input int cfg, input int d);
    int n;
    int exp_lock;
    bus.pll_en_i = 1'b0;
    tick();
    bus.settle_cyc_i   = 8'(s);
    bus.lock_cyc_i     = 8'(nl);
    bus.timeout_i      = 16'd0;
    bus.clk_cfg_i      = 3'(cfg);
    bus.pll_lock_raw_i = 1'b0;
    bus.pll_en_i       = 1'b1;
    tick();
    n_cmp += 3;
    if (bus.state_o !== 3'(S_RST)) begin n_bad++; $display("FAIL %s_enter_rst: got %0d want %0d", tag, bus.state_o, S_RST); end
    if (bus.pll_pd_o !== 1'b0)     begin n_bad++; $display("FAIL %s_rst_pd: got %0b want 0", tag, bus.pll_pd_o); end
    if (bus.pll_rst_o !== 1'b1)    begin n_bad++; $display("FAIL %s_rst_rst: got %0b want 1", tag, bus.pll_rst_o); end
    wait_until(K_STATE, S_WAIT, 600, n);
    n_cmp += 2;
    if (n !== s + 1)                  begin n_bad++; $display("FAIL %s_rst_cycles: got %0d want %0d", tag, n, s + 1); end
    if (bus.pll_cfg_o !== 3'(cfg))    begin n_bad++; $display("FAIL %s_cfg: got %0d want %0d", tag, bus.pll_cfg_o, cfg); end
    repeat (d) tick();
    bus.pll_lock_raw_i = 1'b1;
    exp_lock = 2 + ((nl == 0) ? 1 : nl);
    wait_until(K_LOCK, 1, 600, n);
    n_cmp += 3;
    if (n !== exp_lock)              begin n_bad++; $display("FAIL %s_lock_edges: got %0d want %0d", tag, n, exp_lock); end
    if (bus.pll_rst_o !== 1'b0)      begin n_bad++; $display("FAIL %s_locked_rst: got %0b want 0", tag, bus.pll_rst_o); end
    if (bus.relock_cnt_o !== 8'(relock_model)) begin n_bad++; $display("FAIL %s_relock: got %0d want %0d", tag, bus.relock_cnt_o, relock_model); end
    $display("[%0t] %s: settle=%0d lock_cyc=%0d cfg=%0d rst_cycles=%0d lock_edges=%0d", $time, tag, s, nl, cfg, s + 1, n);
  endtask

  task automatic test_normal_lock();
    run_lock("normal", 4, 8, 3, 10);
  endtask

  task automatic test_random_lock();
    for (int i = 0; i < 6; i++) begin
      run_lock("rand_lock", int'($urandom_range(0, 12)), (i == 0) ? 0 : int'($urandom_range(1, 10)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 5)));
    end
  endtask

  // Raw lock high g < N cycles, low for a while, then high: only the final run may lock.
  task automatic test_glitch();
    int n;
    int nl;
    int g;
    int low;
    bit early;
    for (int i = 0; i < 4; i++) begin
      nl  = (i == 0) ? 8 : int'($urandom_range(2, 12));
      g   = (i == 0) ? 5 : int'($urandom_range(1, nl - 1));
      low = (i == 0) ? 1 : int'($urandom_range(1, 3));
      to_wait(1, nl, 0, 1, 1'b0);
      early = 0;
      bus.pll_lock_raw_i = 1'b1;
      repeat (g) begin tick(); early |= bus.pll_lock_o; end
      bus.pll_lock_raw_i = 1'b0;
      repeat (low) begin tick(); early |= bus.pll_lock_o; end
      bus.pll_lock_raw_i = 1'b1;
      wait_until(K_LOCK, 1, 100, n);
      n_cmp += 2;
      if (early !== 1'b0)  begin n_bad++; $display("FAIL glitch_early_lock: got %0b want 0", early); end
      if (n !== 2 + nl)    begin n_bad++; $display("FAIL glitch_lock_edges: got %0d want %0d", n, 2 + nl); end
      $display("[%0t] glitch: lock_cyc=%0d high=%0d low=%0d lock_edges=%0d", $time, nl, g, low, n);
    end
  endtask

  task automatic test_timeout();
    int n;
    int t;
    for (int i = 0; i < 4; i++) begin
      t = (i == 0) ? 20 : (i == 1) ? 1 : int'($urandom_range(2, 40));
      to_wait(2, 8, t, 2, 1'b0);
      wait_until(K_STATE, S_FAIL, 200, n);
      n_cmp += 5;
      if (n !== t)                  begin n_bad++; $display("FAIL tmo_edges: got %0d want %0d", n, t); end
      if (bus.timeout_o !== 1'b1)   begin n_bad++; $display("FAIL tmo_flag: got %0b want 1", bus.timeout_o); end
      if (bus.pll_pd_o !== 1'b1)    begin n_bad++; $display("FAIL tmo_pd: got %0b want 1", bus.pll_pd_o); end
      if (bus.pll_rst_o !== 1'b1)   begin n_bad++; $display("FAIL tmo_rst: got %0b want 1", bus.pll_rst_o); end
      if (bus.pll_lock_o !== 1'b0)  begin n_bad++; $display("FAIL tmo_lock: got %0b want 0", bus.pll_lock_o); end
      bus.pll_lock_raw_i = 1'b1;
      repeat (15) tick();
      n_cmp++;
      if (bus.state_o !== 3'(S_FAIL)) begin n_bad++; $display("FAIL tmo_hold: got %0d want %0d", bus.state_o, S_FAIL); end
      bus.clk_cfg_i = 3'd6;
      tick();
      n_cmp += 3;
      if (bus.state_o !== 3'(S_RST)) begin n_bad++; $display("FAIL tmo_recfg_state: got %0d want %0d", bus.state_o, S_RST); end
      if (bus.timeout_o !== 1'b0)    begin n_bad++; $display("FAIL tmo_recfg_flag: got %0b want 0", bus.timeout_o); end
      if (bus.pll_cfg_o !== 3'd6)    begin n_bad++; $display("FAIL tmo_recfg_cfg: got %0d want 6", bus.pll_cfg_o); end
      $display("[%0t] timeout: timeout=%0d fail_edges=%0d", $time, t, n);
    end
    // Lock and timeout landing on the same edge: lock must win.
    to_wait(0, 4, 20, 1, 1'b0);
    repeat (20 - 2 - 4) tick();
    bus.pll_lock_raw_i = 1'b1;
    wait_until(K_NOT_STATE, S_WAIT, 50, n);
    n_cmp += 2;
    if (n !== 6)                       begin n_bad++; $display("FAIL tie_edges: got %0d want 6", n); end
    if (bus.state_o !== 3'(S_LOCKED))  begin n_bad++; $display("FAIL tie_state: got %0d want %0d", bus.state_o, S_LOCKED); end
    $display("[%0t] timeout_tie: state=%0d", $time, bus.state_o);
    // A zero timeout never expires.
    to_wait(0, 4, 0, 1, 1'b0);
    repeat (300) tick();
    n_cmp++;
    if (bus.state_o !== 3'(S_WAIT)) begin n_bad++; $display("FAIL tmo_disabled: got %0d want %0d", bus.state_o, S_WAIT); end
    $display("[%0t] timeout_disabled: state=%0d", $time, bus.state_o);
  endtask

  task automatic test_lock_loss();
    int n;
    to_wait(0, 1, 0, 3, 1'b1);
    wait_until(K_LOCK, 1, 50, n);
    n_cmp++;
    if (n < 0) begin n_bad++; $display("FAIL loss_initial_lock: got timeout want lock"); end
    for (int i = 0; i < 300; i++) begin
      bus.pll_lock_raw_i = 1'b0;
      tick();
      bus.pll_lock_raw_i = 1'b1;
      wait_until(K_LOST, 1, 10, n);
      relock_model = (relock_model < 255) ? relock_model + 1 : 255;
      n_cmp += 4;
      if (n + 1 !== 3)                 begin n_bad++; $display("FAIL loss_edges: got %0d want 3", n + 1); end
      if (bus.pll_lock_o !== 1'b0)     begin n_bad++; $display("FAIL loss_lock: got %0b want 0", bus.pll_lock_o); end
      if (bus.state_o !== 3'(S_RST))   begin n_bad++; $display("FAIL loss_state: got %0d want %0d", bus.state_o, S_RST); end
      if (bus.relock_cnt_o !== 8'(relock_model)) begin n_bad++; $display("FAIL loss_relock: got %0d want %0d", bus.relock_cnt_o, relock_model); end
      tick();
      n_cmp++;
      if (bus.lock_lost_o !== 1'b0)    begin n_bad++; $display("FAIL loss_pulse_width: got %0b want 0", bus.lock_lost_o); end
      wait_until(K_LOCK, 1, 50, n);
      n_cmp++;
      if (n < 0) begin n_bad++; $display("FAIL loss_relock_wait: got timeout want lock"); end
      $display("[%0t] lock_loss %0d: relock_cnt=%0d", $time, i, bus.relock_cnt_o);
    end
  endtask

  task automatic test_reconfig();
    int n;
    to_wait(0, 2, 0, 3, 1'b1);
    wait_until(K_LOCK, 1, 50, n);
    bus.clk_cfg_i = 3'd5;
    tick();
    n_cmp += 3;
    if (bus.pll_cfg_o !== 3'd5)     begin n_bad++; $display("FAIL recfg_cfg: got %0d want 5", bus.pll_cfg_o); end
    if (bus.pll_lock_o !== 1'b0)    begin n_bad++; $display("FAIL recfg_lock: got %0b want 0", bus.pll_lock_o); end
    if (bus.state_o !== 3'(S_RST))  begin n_bad++; $display("FAIL recfg_state: got %0d want %0d", bus.state_o, S_RST); end
    wait_until(K_LOCK, 1, 50, n);
    n_cmp++;
    if (n < 0) begin n_bad++; $display("FAIL recfg_relock: got timeout want lock"); end
    $display("[%0t] reconfig 3->5: cfg=%0d relocked_edges=%0d", $time, bus.pll_cfg_o, n);
    bus.clk_cfg_i = 3'd3;
    tick();
    wait_until(K_LOCK, 1, 50, n);
    // Disable and config change together: disable wins, configuration is kept.
    bus.clk_cfg_i = 3'd5;
    bus.pll_en_i  = 1'b0;
    tick();
    n_cmp += 5;
    if (bus.state_o !== 3'(S_OFF))  begin n_bad++; $display("FAIL off_wins_state: got %0d want %0d", bus.state_o, S_OFF); end
    if (bus.pll_cfg_o !== 3'd3)     begin n_bad++; $display("FAIL off_wins_cfg: got %0d want 3", bus.pll_cfg_o); end
    if (bus.pll_lock_o !== 1'b0)    begin n_bad++; $display("FAIL off_wins_lock: got %0b want 0", bus.pll_lock_o); end
    if (bus.pll_pd_o !== 1'b1)      begin n_bad++; $display("FAIL off_wins_pd: got %0b want 1", bus.pll_pd_o); end
    if (bus.relock_cnt_o !== 8'(relock_model)) begin n_bad++; $display("FAIL off_relock_kept: got %0d want %0d", bus.relock_cnt_o, relock_model); end
    $display("[%0t] disable+reconfig: state=%0d cfg=%0d", $time, bus.state_o, bus.pll_cfg_o);
    // A config change while in RST restarts the settle period from the change.
    bus.settle_cyc_i = 8'd6;
    bus.clk_cfg_i    = 3'd3;
    bus.pll_en_i     = 1'b1;
    repeat (3) tick();
    bus.clk_cfg_i = 3'd4;
    wait_until(K_STATE, S_WAIT, 50, n);
    n_cmp++;
    if (n !== 8) begin n_bad++; $display("FAIL rst_restart_edges: got %0d want 8", n); end
    $display("[%0t] reconfig_in_rst: wait_edges=%0d", $time, n);
  endtask

  task automatic test_async_reset();
    int n;
    to_wait(1, 2, 0, 6, 1'b1);
    wait_until(K_LOCK, 1, 50, n);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (bus.pll_lock_o !== 1'b0)    begin n_bad++; $display("FAIL arst_lock: got %0b want 0", bus.pll_lock_o); end
    if (bus.pll_pd_o !== 1'b1)      begin n_bad++; $display("FAIL arst_pd: got %0b want 1", bus.pll_pd_o); end
    if (bus.pll_rst_o !== 1'b1)     begin n_bad++; $display("FAIL arst_rst: got %0b want 1", bus.pll_rst_o); end
    if (bus.state_o !== 3'd0)       begin n_bad++; $display("FAIL arst_state: got %0d want 0", bus.state_o); end
    if (bus.pll_cfg_o !== 3'd0)     begin n_bad++; $display("FAIL arst_cfg: got %0d want 0", bus.pll_cfg_o); end
    if (bus.relock_cnt_o !== 8'd0)  begin n_bad++; $display("FAIL arst_relock: got %0d want 0", bus.relock_cnt_o); end
    relock_model = 0;
    $display("[%0t] async_reset: lock=%0b pd=%0b state=%0d", $time, bus.pll_lock_o, bus.pll_pd_o, bus.state_o);
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    relock_model = 0;
    rst_n = 1'b0;
    bus.pll_en_i       = 1'b0;
    bus.clk_cfg_i      = 3'd0;
    bus.settle_cyc_i   = 8'd0;
    bus.lock_cyc_i     = 8'd0;
    bus.timeout_i      = 16'd0;
    bus.pll_lock_raw_i = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_normal_lock();
    test_random_lock();
    test_glitch();
    test_timeout();
    test_lock_loss();
    test_reconfig();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
